// File: rtl/tff_seq_pkg.sv
// Shared types for the toggle flip-flop sequencer.
// State encoding, default widths and a small state helper.
`timescale 1ns/1ps

package tff_seq_pkg;

    localparam int DEF_CNT_W = 8;
    localparam int DEF_PER_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        PULSE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    // States in which a running command can be aborted.
    function automatic logic abortable(input state_t s);
        return (s == WAIT) || (s == PULSE) || (s == CHECK);
    endfunction

endpackage

// File: rtl/tff_gap_counter.sv
// Inter-pulse gap counter: loadable, decrements toward zero, never wraps.
// Ports: clk, rst_n, load/load_val, dec, count, zero.
`timescale 1ns/1ps

module tff_gap_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/tff_toggle_sequencer.sv
// Toggle flip-flop controller: issues N single-cycle t pulses, P idle cycles
// before each, checks q after every pulse. Ports: cmd valid/ready/count/period/abort,
// t out, q_in feedback, busy/done/aborted/err status, toggles_done.
`timescale 1ns/1ps

module tff_toggle_sequencer
    import tff_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PER_W = DEF_PER_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [PER_W-1:0] cmd_period,
    input  logic             cmd_abort,
    output logic             t,
    input  logic             q_in,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err,
    output logic [CNT_W-1:0] toggles_done
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] toggles_q, toggles_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             exp_q, exp_d;
    logic             aborted_q, aborted_d;
    logic             err_q, err_d;

    logic             gap_load;
    logic [PER_W-1:0] gap_val;
    logic             gap_dec;
    logic [PER_W-1:0] gap_count;
    logic             gap_zero;
    logic             mismatch;
    logic             abort_now;

    tff_gap_counter #(
        .W (PER_W)
    ) u_gap (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (gap_load),
        .load_val (gap_val),
        .dec      (gap_dec),
        .count    (gap_count),
        .zero     (gap_zero)
    );

    assign mismatch  = (q_in != exp_q);
    assign abort_now = cmd_abort && abortable(state_q);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        toggles_d   = toggles_q;
        period_d    = period_q;
        exp_d       = exp_q;
        aborted_d   = aborted_q;
        err_d       = err_q;
        gap_load    = 1'b0;
        gap_dec     = 1'b0;
        // Reloads from CHECK use the latched period; the first load
        // comes straight from the command bus on accept.
        gap_val     = period_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    aborted_d = 1'b0;
                    err_d     = 1'b0;
                    toggles_d = '0;
                    period_d  = cmd_period;
                    exp_d     = q_in;
                    if (cmd_count == '0) begin
                        state_d = DONE;
                    end else begin
                        remaining_d = cmd_count;
                        gap_load    = 1'b1;
                        gap_val     = cmd_period;
                        state_d     = WAIT;
                    end
                end
            end
            WAIT: begin
                if (abort_now) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if (gap_zero) begin
                    state_d = PULSE;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            PULSE: begin
                // The pulse is already on the wire, so it counts even if aborted.
                exp_d     = ~exp_q;
                toggles_d = toggles_q + CNT_W'(1);
                if (abort_now) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    err_d = 1'b1;
                end
                if (abort_now) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if (mismatch) begin
                    state_d = DONE;
                end else if (remaining_q == CNT_W'(1)) begin
                    state_d = DONE;
                end else begin
                    remaining_d = remaining_q - CNT_W'(1);
                    gap_load    = 1'b1;
                    state_d     = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            toggles_q   <= '0;
            period_q    <= '0;
            exp_q       <= 1'b0;
            aborted_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            toggles_q   <= toggles_d;
            period_q    <= period_d;
            exp_q       <= exp_d;
            aborted_q   <= aborted_d;
            err_q       <= err_d;
        end
    end

    // All handshake and drive outputs decode registered state only.
    assign t            = (state_q == PULSE);
    assign busy         = (state_q != IDLE);
    assign cmd_ready    = (state_q == IDLE);
    assign done         = (state_q == DONE);
    assign aborted      = aborted_q;
    assign err          = err_q;
    assign toggles_done = toggles_q;

    logic unused_gap;
    assign unused_gap = ^gap_count;

endmodule
